// File: rtl/dump_sequencer_if.sv
// dump_sequencer_if: scheduler request/ack plus dump-state mux and state RAM write port
interface dump_sequencer_if #(
    parameter int CH_ADDR_W = 5
);
    logic                   dump_en;
    logic [3:0]             dump_req;
    logic [4*CH_ADDR_W-1:0] logical_ch;
    logic [1:0]             physical_channel_index;
    logic [4:0]             state_addr;
    logic [31:0]            state_d4wt;
    logic                   state_we;
    logic [CH_ADDR_W+4:0]   state_waddr;
    logic [31:0]            state_wdata;
    logic [3:0]             dump_ack;
    logic                   busy;

    modport master (
        input  dump_en, dump_req, logical_ch, state_d4wt,
        output physical_channel_index, state_addr, state_we, state_waddr, state_wdata, dump_ack, busy
    );

    modport slave (
        output dump_en, dump_req, logical_ch, state_d4wt,
        input  physical_channel_index, state_addr, state_we, state_waddr, state_wdata, dump_ack, busy
    );
endinterface

// File: rtl/dump_sequencer.sv
// dump_sequencer: round-robin dump of correlator channel state words into the channel state memory
module dump_sequencer #(
    parameter int CH_ADDR_W = 5
) (
    input logic              clk,
    input logic              rst,
    dump_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state;
    state_t                 state_n;
    logic [3:0]             pending;
    logic [3:0]             grant_oh;
    logic [1:0]             rr;
    logic [1:0]             grant_ch;
    logic                   grant;
    logic [1:0]             pci;
    logic [CH_ADDR_W-1:0]   lch;
    logic [4:0]             addr;
    logic [4:0]             addr_n;
    logic                   we;
    logic [CH_ADDR_W+4:0]   waddr;

    // Arbiter: lowest offset from rr among pending channels wins (loop runs downward so it lands last)
    always_comb begin
        grant_ch = rr;
        for (int i = 3; i >= 0; i--)
            if (pending[rr + 2'(i)]) grant_ch = rr + 2'(i);
        grant    = state == IDLE && bus.dump_en && |pending;
        grant_oh = grant ? 4'b0001 << grant_ch : 4'b0000;
    end

    // Next state and next word select; word 14 is not part of the dumped state
    always_comb begin
        state_n = state;
        addr_n  = 5'd0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_n = ISSUE;
                    addr_n  = 5'd6;
                end
            end
            ISSUE: begin
                if (addr == 5'd16) state_n = DRAIN;
                else addr_n = addr == 5'd13 ? 5'd15 : addr + 5'd1;
            end
            DRAIN:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM, pending set/clear and word select; a request in the grant cycle keeps its bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 4'b0000;
            addr    <= 5'd0;
        end else begin
            state   <= state_n;
            pending <= (pending & ~grant_oh) | bus.dump_req;
            addr    <= addr_n;
        end
    end

    // Grant latches: channel select, logical channel and round-robin pointer move only on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr  <= 2'd0;
            pci <= 2'd0;
            lch <= '0;
        end else if (grant) begin
            rr  <= grant_ch + 2'd1;
            pci <= grant_ch;
            lch <= bus.logical_ch[grant_ch*CH_ADDR_W +: CH_ADDR_W];
        end
    end

    // Write path lags the word select by one cycle to line up with the mux output
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
        end else begin
            we    <= state == ISSUE;
            waddr <= {lch, addr};
        end
    end

    assign bus.physical_channel_index = pci;
    assign bus.state_addr             = addr;
    assign bus.state_we               = we;
    assign bus.state_waddr            = waddr;
    assign bus.state_wdata            = bus.state_d4wt;
    assign bus.dump_ack               = state == DRAIN ? 4'b0001 << pci : 4'b0000;
    assign bus.busy                   = state != IDLE;
endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer: directed and random stimulus against a transaction-level scoreboard model
module tb_dump_sequencer;
    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        int         cyc;
        logic [3:0] v;
    } ack_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   seq[10] = '{6, 7, 8, 9, 10, 11, 12, 13, 15, 16};

    wr_t  wq[$];
    ack_t aq[$];
    logic [3:0] pend = 4'b0000;
    int   rr_m = 0;
    int   g_cyc = -100;
    int   g_ch = 0;
    int   g;

    dump_sequencer_if #(.CH_ADDR_W(5)) bus ();

    dump_sequencer #(.CH_ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Dump-state mux: word for (channel, addr) appears one cycle after selection
    always @(posedge clk)
        bus.state_d4wt <= {16'hC0DE, 6'd0, bus.physical_channel_index, 3'd0, bus.state_addr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pending set, round-robin pick, one dump of 10 words per 12 cycles
    always @(posedge clk) begin
        if (rst) begin
            pend  = 4'b0000;
            rr_m  = 0;
            g_cyc = -100;
            g_ch  = 0;
            wq.delete();
            aq.delete();
        end else begin
            if (cyc >= g_cyc + 12 && bus.dump_en && pend != 4'b0000) begin
                g = -1;
                for (int i = 0; i < 4; i++)
                    if (g < 0 && pend[(rr_m + i) % 4]) g = (rr_m + i) % 4;
                for (int k = 0; k < 10; k++)
                    wq.push_back('{cyc + 2 + k, {bus.logical_ch[g*5 +: 5], 5'(seq[k])},
                                   {16'hC0DE, 6'd0, 2'(g), 3'd0, 5'(seq[k])}});
                aq.push_back('{cyc + 11, 4'(1 << g)});
                pend[g] = 1'b0;
                rr_m    = (g + 1) % 4;
                g_cyc   = cyc;
                g_ch    = g;
            end
            pend = pend | bus.dump_req;
        end
        cyc++;
    end

    // Monitor: per-cycle outputs against model, writes and acks popped from the scoreboard
    always @(negedge clk) begin
        int   k;
        logic exp_we;
        logic [3:0] exp_ack;
        if (cyc >= 1) begin
            k = cyc - g_cyc - 1;
            chk("busy", 32'(bus.busy), 32'(k >= 0 && k <= 10));
            chk("state_addr", 32'(bus.state_addr), (k >= 0 && k < 10) ? 32'(seq[k]) : 32'd0);
            chk("phys_idx", 32'(bus.physical_channel_index), 32'(g_ch));
            exp_we = wq.size() > 0 && wq[0].cyc == cyc;
            chk("state_we", 32'(bus.state_we), 32'(exp_we));
            if (exp_we) begin
                if (bus.state_we) begin
                    chk("state_waddr", 32'(bus.state_waddr), 32'(wq[0].addr));
                    chk("state_wdata", bus.state_wdata, wq[0].data);
                end
                void'(wq.pop_front());
            end
            exp_ack = (aq.size() > 0 && aq[0].cyc == cyc) ? aq[0].v : 4'b0000;
            chk("dump_ack", 32'(bus.dump_ack), 32'(exp_ack));
            if (exp_ack != 4'b0000) void'(aq.pop_front());
        end
    end

    task automatic step(input logic [3:0] req, input logic en, input logic r);
        @(negedge clk);
        #1;
        bus.dump_req = req;
        bus.dump_en  = en;
        rst          = r;
    endtask

    task automatic idle(input int n, input logic en);
        repeat (n) step(4'b0000, en, 1'b0);
    endtask

    initial begin
        bus.dump_req   = 4'b0000;
        bus.dump_en    = 1'b0;
        bus.logical_ch = {5'd21, 5'd9, 5'd3, 5'd17};
        repeat (3) step(4'b0000, 1'b0, 1'b1);
        idle(2, 1'b1);
        // single dump of physical channel 2, logical channel 9
        step(4'b0100, 1'b1, 1'b0);
        idle(14, 1'b1);
        // round robin over all four, then 0,1
        step(4'b1111, 1'b1, 1'b0);
        idle(52, 1'b1);
        step(4'b0011, 1'b1, 1'b0);
        idle(28, 1'b1);
        // re-request during own dump, logical channel changed mid-dump
        step(4'b0010, 1'b1, 1'b0);
        idle(4, 1'b1);
        bus.logical_ch = {5'd30, 5'd1, 5'd12, 5'd5};
        step(4'b0010, 1'b1, 1'b0);
        idle(30, 1'b1);
        // dump_en held low, then dropped mid-dump, then raised
        step(4'b1001, 1'b0, 1'b0);
        idle(10, 1'b0);
        idle(4, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        idle(24, 1'b0);
        idle(40, 1'b1);
        // reset at G+5
        step(4'b0001, 1'b1, 1'b0);
        idle(5, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        idle(3, 1'b1);
        step(4'b0100, 1'b1, 1'b0);
        idle(14, 1'b1);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.logical_ch = 20'($urandom);
            step(($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0);
        end
        idle(60, 1'b1);
        chk("writes_left", 32'(wq.size()), 32'd0);
        chk("acks_left", 32'(aq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
